trig_pid_tdc: RTL

Parametrised successor to the fixed 48-channel trigger TDC/PID path. Measures the time-of-flight from a reference (start) hit to the first detector hit among NCH channels, and classifies it against three register-programmable windows (electron, muon, pion). Emits one-cycle PID pulses split by detector half (up/down) and keeps saturating per-class and timeout counters. These are readable on the shared local bus (Address/Read/Write/DataIn/DataOut, OR-combined DataOut).

---
 rtl/trig_pid_tdc.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/trig_pid_tdc.sv
// ============================================================================
// Module   : trig_pid_tdc
// Purpose  : Start-to-first-hit time-of-flight TDC with three programmable
//            PID windows, up/down split pulses and local-bus counters.
// Revision : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

module trig_pid_tdc #(
  parameter int          NCH       = 48,
  parameter int          TW        = 12,
  parameter int          MAX_WIN   = 400,
  parameter logic [7:0]  BASE_ADDR = 8'hD0,
  parameter int          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    hit_in,
  input  logic              ref_in,
  output logic              Electron,
  output logic              Muon,
  output logic              Pion,
  output logic              Electronup,
  output logic              Muonup,
  output logic              Pionup,
  output logic              Electrondown,
  output logic              Muondown,
  output logic              Piondown,
  output logic              busy,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  input  logic [7:0]        Address,
  input  logic              Read,
  input  logic              Write,
  output logic              ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_DECIDE = 2'd2
  } state_t;

  localparam logic [TW-1:0]    c_max_win = TW'(MAX_WIN);
  localparam logic [5:0]       c_half    = 6'(NCH / 2);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t              r_state;
  logic [NCH-1:0]      r_hit_q;
  logic                r_ref_q;
  logic [TW-1:0]       r_tof;
  logic [TW-1:0]       r_dt;
  logic [5:0]          r_ch;
  logic [7:0]          r_to_cnt;
  logic                r_enable;
  logic [TW-1:0]       r_win_lo [3];
  logic [TW-1:0]       r_win_hi [3];
  logic [CNT_W-1:0]    r_cnt    [3];

  logic [NCH-1:0]      w_hit_edge;
  logic                w_ref_edge;
  logic                w_any_hit;
  logic [5:0]          w_first_ch;
  logic [2:0]          w_in_win;
  logic [2:0]          w_cls;
  logic                w_up;
  logic [7:0]          w_off;
  logic                w_sel;
  logic                w_wr;
  logic                w_unused_din;

  assign w_hit_edge   = hit_in & ~r_hit_q;
  assign w_ref_edge   = ref_in & ~r_ref_q;
  assign w_any_hit    = |w_hit_edge;
  assign busy         = (r_state != S_IDLE);
  assign w_unused_din = ^DataIn;

  // Descending scan so the lowest active channel is the one left standing.
  always_comb begin
    w_first_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_hit_edge[i]) w_first_ch = 6'(i);
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_in_win[k] = (r_dt >= r_win_lo[k]) && (r_dt <= r_win_hi[k]);
    end
  end

  assign w_cls[0] = w_in_win[0];
  assign w_cls[1] = w_in_win[1] & ~w_in_win[0];
  assign w_cls[2] = w_in_win[2] & ~w_in_win[1] & ~w_in_win[0];
  assign w_up     = (r_ch < c_half);

  assign w_off = Address - BASE_ADDR;
  assign w_sel = (w_off < 8'd8);
  assign w_wr  = w_sel & Write;
  assign ack   = w_sel & (Read | Write);

  function automatic logic [31:0] f_win_word(input logic [TW-1:0] lo, input logic [TW-1:0] hi);
    f_win_word = (32'(hi) << 16) | 32'(lo);
  endfunction

  always_comb begin
    DataOut = '0;
    if (Read && w_sel) begin
      case (w_off[2:0])
        3'd0:    DataOut = {31'd0, r_enable};
        3'd1:    DataOut = f_win_word(r_win_lo[0], r_win_hi[0]);
        3'd2:    DataOut = f_win_word(r_win_lo[1], r_win_hi[1]);
        3'd3:    DataOut = f_win_word(r_win_lo[2], r_win_hi[2]);
        3'd4:    DataOut = 32'(r_cnt[0]);
        3'd5:    DataOut = 32'(r_cnt[1]);
        3'd6:    DataOut = 32'(r_cnt[2]);
        default: DataOut = {r_to_cnt, 2'b00, r_ch, 12'(r_dt), 2'b00, r_state};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_q <= '0;
      r_ref_q <= 1'b0;
    end else begin
      r_hit_q <= hit_in;
      r_ref_q <= ref_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable    <= 1'b1;
      r_win_lo[0] <= TW'(1);
      r_win_hi[0] <= TW'(20);
      r_win_lo[1] <= TW'(21);
      r_win_hi[1] <= TW'(60);
      r_win_lo[2] <= TW'(61);
      r_win_hi[2] <= TW'(120);
    end else if (w_wr) begin
      case (w_off[2:0])
        3'd0: r_enable <= DataIn[0];
        3'd1: begin r_win_lo[0] <= DataIn[TW-1:0]; r_win_hi[0] <= DataIn[16+TW-1:16]; end
        3'd2: begin r_win_lo[1] <= DataIn[TW-1:0]; r_win_hi[1] <= DataIn[16+TW-1:16]; end
        3'd3: begin r_win_lo[2] <= DataIn[TW-1:0]; r_win_hi[2] <= DataIn[16+TW-1:16]; end
        default: ;
      endcase
    end
  end

  // A bus clear landing on the same edge as an increment leaves zero.
  for (genvar k = 0; k < 3; k++) begin : g_cnt
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt[k] <= '0;
      end else if (w_wr && (w_off[2:0] == 3'(4 + k))) begin
        r_cnt[k] <= '0;
      end else if ((r_state == S_DECIDE) && w_cls[k] && (r_cnt[k] != c_cnt_max)) begin
        r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_tof        <= '0;
      r_dt         <= '0;
      r_ch         <= '0;
      r_to_cnt     <= '0;
      Electron     <= 1'b0;
      Muon         <= 1'b0;
      Pion         <= 1'b0;
      Electronup   <= 1'b0;
      Muonup       <= 1'b0;
      Pionup       <= 1'b0;
      Electrondown <= 1'b0;
      Muondown     <= 1'b0;
      Piondown     <= 1'b0;
    end else begin
      Electron     <= 1'b0;
      Muon         <= 1'b0;
      Pion         <= 1'b0;
      Electronup   <= 1'b0;
      Muonup       <= 1'b0;
      Pionup       <= 1'b0;
      Electrondown <= 1'b0;
      Muondown     <= 1'b0;
      Piondown     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ref_edge && r_enable) begin
            r_tof   <= TW'(1);
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          r_tof <= r_tof + 1'b1;
          if (!r_enable) begin
            r_state <= S_IDLE;
          end else if (w_any_hit) begin
            r_dt    <= r_tof;
            r_ch    <= w_first_ch;
            r_state <= S_DECIDE;
          end else if (r_tof == c_max_win) begin
            if (r_to_cnt != 8'hFF) r_to_cnt <= r_to_cnt + 8'd1;
            r_state <= S_IDLE;
          end
        end
        S_DECIDE: begin
          Electron     <= w_cls[0];
          Muon         <= w_cls[1];
          Pion         <= w_cls[2];
          Electronup   <= w_cls[0] & w_up;
          Muonup       <= w_cls[1] & w_up;
          Pionup       <= w_cls[2] & w_up;
          Electrondown <= w_cls[0] & ~w_up;
          Muondown     <= w_cls[1] & ~w_up;
          Piondown     <= w_cls[2] & ~w_up;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_wr && (w_off[2:0] == 3'd7)) r_to_cnt <= 8'd0;
    end
  end

endmodule

`default_nettype wire
